// File: rtl/pcnn_mc_if.sv
// pcnn_mc_if: handshake/data bundle between a stream source and pcnn_mc.
// Carries go/relu, filter and pixel streams, and the result handshake.
interface pcnn_mc_if #(
  parameter int DW = 8,
  parameter int FW = 9,
  parameter int OW = 20
);
  logic          go;
  logic          relu;
  logic [FW-1:0] f;
  logic          f_valid;
  logic [DW-1:0] a;
  logic          a_valid;
  logic          out_ready;
  logic [OW-1:0] out;
  logic          out_valid;
  logic          busy;
  logic          done;

  modport master (
    output go, relu, f, f_valid, a, a_valid, out_ready,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  go, relu, f, f_valid, a, a_valid, out_ready,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/pcnn_mc.sv
// pcnn_mc: multi-channel 2D convolution, one MAC per cycle, zero padding.
// Ports: clk, reset (async, active-low), bus (pcnn_mc_if slave).
module pcnn_mc #(
  parameter int A_SIZE = 6,
  parameter int F_SIZE = 3,
  parameter int STRIDE = 1,
  parameter int ZP     = 0,
  parameter int CH     = 2,
  parameter int DW     = 8,
  parameter int FW     = 9,
  parameter int OW     = 20
) (
  input  logic      clk,
  input  logic      reset,
  pcnn_mc_if.slave  bus
);

  localparam int NT   = CH * F_SIZE * F_SIZE;
  localparam int NA   = CH * A_SIZE * A_SIZE;
  localparam int NL   = (NA > NT) ? NA : NT;
  localparam int OS   = (A_SIZE + 2 * ZP - F_SIZE) / STRIDE + 1;
  localparam int PW   = DW + 1 + FW;
  localparam int ACCW = DW + FW + $clog2(NT) + 1;
  localparam int XW   = ((ACCW > OW) ? ACCW : OW) + 1;
  localparam int LW   = $clog2(NL + 1);
  localparam int CW   = $clog2(CH + 1);
  localparam int KW   = $clog2(F_SIZE + 1);
  localparam int QW   = $clog2(OS + 1);
  localparam int FAW  = (NT > 1) ? $clog2(NT) : 1;
  localparam int AAW  = (NA > 1) ? $clog2(NA) : 1;

  localparam logic signed [XW-1:0] SMAX =
    {{(XW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN =
    {{(XW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, LOADF, LOADA, MAC, EMIT, DONE
  } state_t;

  state_t st;

  logic [FW-1:0] fbuf [2**FAW];
  logic [DW-1:0] abuf [2**AAW];

  logic [LW-1:0] ld;
  logic [CW-1:0] cc;
  logic [KW-1:0] fi;
  logic [KW-1:0] fj;
  logic [QW-1:0] orow;
  logic [QW-1:0] ocol;
  logic          fin;
  logic          relu_r;
  logic signed [ACCW-1:0] acc;
  logic [OW-1:0] out_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Buffers hold their contents across runs; every run reloads them.
  always_ff @(posedge clk) begin
    if (st == LOADF && bus.f_valid)
      fbuf[ld[FAW-1:0]] <= bus.f;
    if (st == LOADA && bus.a_valid)
      abuf[ld[AAW-1:0]] <= bus.a;
  end

  int r;
  int q;
  logic pad;
  logic [FAW-1:0] fa;
  logic [AAW-1:0] aa;
  logic [FW-1:0] coef;
  logic [DW-1:0] pix;
  logic signed [PW-1:0] prod;
  logic first;
  logic last_tap;
  logic last_pos;
  logic signed [ACCW-1:0] acc_nx;
  logic signed [XW-1:0] sx;
  logic [OW-1:0] ov;

  // Tap address: coordinates in the unpadded image; off-image taps read 0.
  always_comb begin
    r = int'(orow) * STRIDE + int'(fi) - ZP;
    q = int'(ocol) * STRIDE + int'(fj) - ZP;
    pad = (r < 0) || (r >= A_SIZE) || (q < 0) || (q >= A_SIZE);
    fa = FAW'(int'(cc) * F_SIZE * F_SIZE
       + int'(fi) * F_SIZE + int'(fj));
    aa = '0;
    if (!pad)
      aa = AAW'(int'(cc) * A_SIZE * A_SIZE
         + r * A_SIZE + q);
    coef = fbuf[fa];
    pix = pad ? '0 : abuf[aa];
    prod = $signed({1'b0, pix}) * $signed(coef);
    first = (cc == '0) && (fi == '0) && (fj == '0);
    last_tap = (cc == CW'(CH - 1))
      && (fi == KW'(F_SIZE - 1))
      && (fj == KW'(F_SIZE - 1));
    last_pos = (orow == QW'(OS - 1))
      && (ocol == QW'(OS - 1));
    acc_nx = (first ? '0 : acc) + ACCW'(prod);
  end

  // Relu clamp first, then saturate into the signed output range.
  always_comb begin
    sx = XW'(acc);
    if (relu_r && acc[ACCW-1])
      sx = '0;
    if (sx > SMAX)
      ov = OW'(SMAX);
    else if (sx < SMIN)
      ov = OW'(SMIN);
    else
      ov = OW'(sx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      ld          <= '0;
      cc          <= '0;
      fi          <= '0;
      fj          <= '0;
      orow        <= '0;
      ocol        <= '0;
      fin         <= 1'b0;
      relu_r      <= 1'b0;
      acc         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.go) begin
            st     <= LOADF;
            busy_q <= 1'b1;
            ld     <= '0;
            relu_r <= bus.relu;
          end
        end
        LOADF: begin
          if (bus.f_valid) begin
            if (ld == LW'(NT - 1)) begin
              ld <= '0;
              st <= LOADA;
            end else begin
              ld <= ld + 1'b1;
            end
          end
        end
        LOADA: begin
          if (bus.a_valid) begin
            if (ld == LW'(NA - 1)) begin
              ld   <= '0;
              cc   <= '0;
              fi   <= '0;
              fj   <= '0;
              orow <= '0;
              ocol <= '0;
              fin  <= 1'b0;
              st   <= MAC;
            end else begin
              ld <= ld + 1'b1;
            end
          end
        end
        MAC: begin
          // N product cycles, then one cycle to register the result.
          if (!fin) begin
            acc <= acc_nx;
            if (fj == KW'(F_SIZE - 1)) begin
              fj <= '0;
              if (fi == KW'(F_SIZE - 1)) begin
                fi <= '0;
                cc <= last_tap ? '0 : cc + 1'b1;
              end else begin
                fi <= fi + 1'b1;
              end
            end else begin
              fj <= fj + 1'b1;
            end
            if (last_tap)
              fin <= 1'b1;
          end else begin
            fin         <= 1'b0;
            out_q       <= ov;
            out_valid_q <= 1'b1;
            st          <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (last_pos) begin
              st     <= DONE;
              done_q <= 1'b1;
            end else begin
              st <= MAC;
              if (ocol == QW'(OS - 1)) begin
                ocol <= '0;
                orow <= orow + 1'b1;
              end else begin
                ocol <= ocol + 1'b1;
              end
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcnn_mc.sv
// tb_pcnn_mc: directed runs of pcnn_mc against an arithmetic reference model.
// Padded 6x6, 2 channels, 12-bit output to reach both saturation limits.
module tb_pcnn_mc;

  localparam int A  = 6;
  localparam int F  = 3;
  localparam int S  = 1;
  localparam int ZP = 1;
  localparam int CH = 2;
  localparam int DW = 8;
  localparam int FW = 9;
  localparam int OW = 12;
  localparam int NT = CH * F * F;
  localparam int NA = CH * A * A;
  localparam int OS = (A + 2 * ZP - F) / S + 1;
  localparam int NR = OS * OS;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pcnn_mc_if #(.DW(DW), .FW(FW), .OW(OW)) bus ();

  pcnn_mc #(
    .A_SIZE(A), .F_SIZE(F), .STRIDE(S), .ZP(ZP),
    .CH(CH), .DW(DW), .FW(FW), .OW(OW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int fv [NT];
  int av [NA];
  int expv [NR];
  int expq [$];
  int acc_cnt = 0;
  int done_cnt = 0;
  int low_run = 0;
  bit armed = 0;
  bit prev_done = 0;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: direct sum over channels and taps of the padded image.
  function automatic int model_at(input int orow, input int ocol,
                                  input bit rl);
    int s;
    int r;
    int q;
    s = 0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < F; i++)
        for (int j = 0; j < F; j++) begin
          r = orow * S + i - ZP;
          q = ocol * S + j - ZP;
          if (r >= 0 && r < A && q >= 0 && q < A)
            s += av[c*A*A + r*A + q] * fv[c*F*F + i*F + j];
        end
    if (rl && s < 0) s = 0;
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    return s;
  endfunction

  task automatic build(input bit rl);
    for (int p = 0; p < NR; p++) begin
      expv[p] = model_at(p / OS, p % OS, rl);
      expq.push_back(expv[p]);
    end
  endtask

  task automatic fill(input int pv, input int cv);
    for (int k = 0; k < NA; k++) av[k] = pv;
    for (int k = 0; k < NT; k++) fv[k] = cv;
  endtask

  task automatic fill_pat();
    for (int k = 0; k < NA; k++) av[k] = (k * 7 + 3) % 16;
    for (int k = 0; k < NT; k++) fv[k] = ((k * 5) % 9) - 4;
  endtask

  // Scoreboard: every cycle with out_valid is compared to the model.
  always @(negedge clk) begin
    int sout;
    if (!reset) begin
      armed = 0;
      low_run = 0;
      prev_done = 0;
    end else begin
      sout = int'($signed(bus.out));
      if (bus.out_valid) begin
        if (armed)
          chk(low_run == NT + 1, "latency", low_run, NT + 1);
        armed = 0;
        low_run = 0;
        chk(bus.busy === 1'b1, "busy_emit", int'(bus.busy), 1);
        if (expq.size() == 0) begin
          chk(1'b0, "unexpected_out", sout, 0);
        end else begin
          chk(sout == expq[0], "out", sout, expq[0]);
          if (bus.out_ready) begin
            void'(expq.pop_front());
            acc_cnt++;
            armed = 1;
          end
        end
      end else begin
        low_run++;
      end
      if (bus.done) begin
        done_cnt++;
        armed = 0;
        chk(expq.size() == 0, "done_early", expq.size(), 0);
        chk(!prev_done, "done_width", 2, 1);
      end
      prev_done = bus.done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit rl);
    bus.relu = rl;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    bus.relu = ~rl;
    bus.a_valid = 1'b1;
    bus.a = 8'hAA;
    for (int k = 0; k < NT; k++) begin
      if (k % 5 == 2) begin
        bus.f_valid = 1'b0;
        tick();
      end
      bus.f = FW'(fv[k]);
      bus.f_valid = 1'b1;
      tick();
    end
    bus.f = 9'h0AB;
    for (int k = 0; k < NA; k++) begin
      if (k % 7 == 3) begin
        bus.a_valid = 1'b0;
        tick();
      end
      bus.a = DW'(av[k]);
      bus.a_valid = 1'b1;
      tick();
    end
    bus.a_valid = 1'b0;
  endtask

  task automatic run(input bit rl, input bit stall,
                     input bit gop, input int abort_at);
    int a0;
    int d0;
    bit stalled;
    bit pulsed;
    logic [OW-1:0] held;
    build(rl);
    a0 = acc_cnt;
    d0 = done_cnt;
    stalled = 0;
    pulsed = 0;
    bus.out_ready = 1'b1;
    load(rl);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done_cnt == d0 + 1) break;
      if (abort_at >= 0 && acc_cnt - a0 == abort_at) begin
        repeat (6) tick();
        #1 reset = 1'b0;
        #1;
        chk(bus.out == '0, "rst_out", int'(bus.out), 0);
        chk(bus.out_valid == 1'b0, "rst_valid",
            int'(bus.out_valid), 0);
        chk(bus.busy == 1'b0, "rst_busy", int'(bus.busy), 0);
        chk(bus.done == 1'b0, "rst_done", int'(bus.done), 0);
        expq.delete();
        tick();
        tick();
        reset = 1'b1;
        bus.f_valid = 1'b0;
        tick();
        return;
      end
      if (stall && !stalled && acc_cnt - a0 == 2 && bus.out_valid) begin
        stalled = 1;
        bus.out_ready = 1'b0;
        held = bus.out;
        for (int w = 0; w < 5; w++) begin
          tick();
          chk(bus.out_valid == 1'b1, "stall_valid",
              int'(bus.out_valid), 1);
          chk(bus.out == held, "stall_out",
              int'($signed(bus.out)), int'($signed(held)));
        end
        bus.out_ready = 1'b1;
      end
      if (gop && !pulsed && acc_cnt - a0 == 4) begin
        pulsed = 1;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
      end
      tick();
    end
    chk(done_cnt == d0 + 1, "run_done", done_cnt - d0, 1);
    chk(acc_cnt - a0 == NR, "result_count", acc_cnt - a0, NR);
    bus.f_valid = 1'b0;
    tick();
    tick();
    chk(bus.busy == 1'b0, "idle_busy", int'(bus.busy), 0);
    chk(done_cnt == d0 + 1, "done_once", done_cnt - d0, 1);
  endtask

  initial begin
    bus.go = 1'b0;
    bus.relu = 1'b0;
    bus.f = '0;
    bus.f_valid = 1'b0;
    bus.a = '0;
    bus.a_valid = 1'b0;
    bus.out_ready = 1'b1;
    #23;
    chk(bus.out == '0, "reset_out", int'(bus.out), 0);
    chk(bus.out_valid == 1'b0, "reset_valid", int'(bus.out_valid), 0);
    chk(bus.busy == 1'b0, "reset_busy", int'(bus.busy), 0);
    chk(bus.done == 1'b0, "reset_done", int'(bus.done), 0);
    reset = 1'b1;
    tick();

    fill(1, 1);
    run(1'b0, 1'b0, 1'b0, -1);
    chk(expv[0] == 8, "pin_corner", expv[0], 8);
    chk(expv[1] == 12, "pin_edge", expv[1], 12);
    chk(expv[7] == 18, "pin_inner", expv[7], 18);

    fill(1, -1);
    run(1'b0, 1'b1, 1'b0, -1);
    chk(expv[7] == -18, "pin_neg", expv[7], -18);

    run(1'b1, 1'b0, 1'b1, -1);
    chk(expv[7] == 0, "pin_relu", expv[7], 0);

    fill(255, 255);
    run(1'b0, 1'b0, 1'b0, -1);
    chk(expv[0] == 2047, "pin_satp", expv[0], 2047);

    fill(255, -256);
    run(1'b0, 1'b1, 1'b0, -1);
    chk(expv[0] == -2048, "pin_satn", expv[0], -2048);

    fill_pat();
    run(1'b0, 1'b1, 1'b1, -1);
    run(1'b1, 1'b0, 1'b0, -1);

    run(1'b0, 1'b0, 1'b0, 3);
    fill(1, 1);
    run(1'b0, 1'b0, 1'b0, -1);
    chk(expv[35] == 8, "pin_after_rst", expv[35], 8);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
